// File: rtl/i2c_eeprom_slave.sv
// i2c_eeprom_slave: byte-addressed I2C EEPROM slave.
// Decodes START/STOP, 7-bit device address, 1-byte word address, byte writes
// and sequential/random reads. SDA is open-drain (drive-low enable only).
// Every committed byte is mirrored on wr_valid/wr_addr/wr_data.
// Optional macro I2C_SLV_PAGE_WRAP_EN: write bursts wrap inside a PAGE_SIZE page.
module i2c_eeprom_slave #(
    parameter logic [6:0]  DEV_ADDR  = 7'h50,
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned PAGE_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i2c_scl,
    input  logic       i2c_sda_in,
    output logic       i2c_sda_oe,
    output logic       busy,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data
);
    localparam int unsigned AW = $clog2(MEM_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_DEV, S_DEV_ACK, S_WADDR, S_WADDR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_WAIT_STOP
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_scl_sync;
    logic [1:0]    r_sda_sync;
    logic          r_scl_d;
    logic          r_sda_d;
    logic [7:0]    r_shift;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_ptr;
    logic          r_ack;
    logic          r_sda_oe;
    logic          r_busy;
    logic          r_wr_valid;
    logic [7:0]    r_wr_addr;
    logic [7:0]    r_wr_data;
    logic [7:0]    r_mem [MEM_DEPTH];

    logic          w_scl;
    logic          w_sda;
    logic          w_scl_rise;
    logic          w_scl_fall;
    logic          w_start;
    logic          w_stop;
    logic          w_byte_done;
    logic          w_addr_match;
    logic [7:0]    w_shift_in;
    logic [7:0]    w_rd_byte;
    logic [AW-1:0] w_rd_ptr_nxt;
    logic [AW-1:0] w_wr_ptr_nxt;
    logic          w_oe_nxt;
    logic          w_busy_nxt;
    logic          w_mem_we;
    logic          w_tx_load;

    // Two-flop synchronizers plus one delayed copy for edge detection; idle bus is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i2c_scl};
            r_sda_sync <= {r_sda_sync[0], i2c_sda_in};
            r_scl_d    <= r_scl_sync[1];
            r_sda_d    <= r_sda_sync[1];
        end
    end

    assign w_scl        = r_scl_sync[1];
    assign w_sda        = r_sda_sync[1];
    assign w_scl_rise   = w_scl & ~r_scl_d;
    assign w_scl_fall   = ~w_scl & r_scl_d;
    // SCL must be high in both samples, so an SDA edge coincident with an SCL edge is ignored
    assign w_start      = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop       = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_byte_done  = (r_cnt == 4'd8);
    assign w_addr_match = (r_shift[7:1] == DEV_ADDR);
    assign w_shift_in   = {r_shift[6:0], w_sda};
    assign w_rd_byte    = r_mem[r_ptr];

    assign w_rd_ptr_nxt = (r_ptr == AW'(MEM_DEPTH - 1)) ? '0 : r_ptr + 1'b1;
`ifdef I2C_SLV_PAGE_WRAP_EN
    localparam logic [AW-1:0] PG_MASK = AW'(PAGE_SIZE - 1);
    assign w_wr_ptr_nxt = (r_ptr & ~PG_MASK) | ((r_ptr + 1'b1) & PG_MASK);
`else
    assign w_wr_ptr_nxt = w_rd_ptr_nxt;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next state: START/STOP win in every state, otherwise advance on SCL fall
    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = S_DEV;
        end else if (w_stop) begin
            w_state_nxt = S_IDLE;
        end else if (w_scl_fall) begin
            case (r_state)
                S_DEV:       if (w_byte_done) w_state_nxt = w_addr_match ? S_DEV_ACK : S_WAIT_STOP;
                S_DEV_ACK:   w_state_nxt = r_shift[0] ? S_RDATA : S_WADDR;
                S_WADDR:     if (w_byte_done) w_state_nxt = S_WADDR_ACK;
                S_WADDR_ACK: w_state_nxt = S_WDATA;
                S_WDATA:     if (w_byte_done) w_state_nxt = S_WDATA_ACK;
                S_WDATA_ACK: w_state_nxt = S_WDATA;
                S_RDATA:     if (w_byte_done) w_state_nxt = S_RACK;
                S_RACK:      w_state_nxt = r_ack ? S_WAIT_STOP : S_RDATA;
                default:     ;
            endcase
        end
    end

    // FSM outputs: next SDA drive, busy flag, memory write strobe, read byte load
    always_comb begin
        w_oe_nxt   = r_sda_oe;
        w_busy_nxt = r_busy;
        w_mem_we   = (r_state == S_WDATA) && w_scl_rise && (r_cnt == 4'd7);
        w_tx_load  = 1'b0;
        if (w_start || w_stop) begin
            w_oe_nxt = 1'b0;
            if (w_stop) w_busy_nxt = 1'b0;
        end else if (w_scl_fall) begin
            case (w_state_nxt)
                S_DEV_ACK, S_WADDR_ACK, S_WDATA_ACK: w_oe_nxt = 1'b1;
                S_RDATA: begin
                    if (r_state != S_RDATA) begin
                        w_tx_load = 1'b1;
                        w_oe_nxt  = ~w_rd_byte[7];
                    end else begin
                        w_oe_nxt  = ~r_shift[6];
                    end
                end
                default: w_oe_nxt = 1'b0;
            endcase
            if (w_state_nxt == S_DEV_ACK)
                w_busy_nxt = 1'b1;
            else if (r_state == S_DEV && w_state_nxt == S_WAIT_STOP)
                w_busy_nxt = 1'b0;
        end
    end

    // Datapath: bit shifting/counting, address pointer, registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_cnt      <= '0;
            r_ptr      <= '0;
            r_ack      <= 1'b1;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_sda_oe   <= w_oe_nxt;
            r_busy     <= w_busy_nxt;
            r_wr_valid <= w_mem_we;
            if (w_start || w_stop) begin
                r_cnt <= '0;
            end else if (w_tx_load) begin
                r_shift <= w_rd_byte;
                r_cnt   <= '0;
                r_ptr   <= w_rd_ptr_nxt;
            end else begin
                case (r_state)
                    S_DEV, S_WADDR, S_WDATA: begin
                        if (w_scl_rise && !w_byte_done) begin
                            r_shift <= w_shift_in;
                            r_cnt   <= r_cnt + 4'd1;
                        end else if (w_scl_fall && w_byte_done) begin
                            r_cnt <= '0;
                            if (r_state == S_WADDR) r_ptr <= AW'(r_shift);
                        end
                        if (w_mem_we) begin
                            r_wr_addr <= 8'(r_ptr);
                            r_wr_data <= w_shift_in;
                            r_ptr     <= w_wr_ptr_nxt;
                        end
                    end
                    S_RDATA: begin
                        if (w_scl_rise)
                            r_cnt <= r_cnt + 4'd1;
                        else if (w_scl_fall && !w_byte_done)
                            r_shift <= {r_shift[6:0], 1'b0};
                    end
                    S_RACK: begin
                        if (w_scl_rise) r_ack <= w_sda;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Byte array: intentionally not reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_ptr] <= w_shift_in;
    end

    assign i2c_sda_oe = r_sda_oe;
    assign busy       = r_busy;
    assign wr_valid   = r_wr_valid;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// tb_i2c_eeprom_slave: bit-banged I2C master driving i2c_eeprom_slave,
// with a byte-array/pointer reference model of the EEPROM.
`timescale 1ns/1ps
module tb_i2c_eeprom_slave;
    localparam int Q = 40;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl   = 1'b1;
    logic       m_rel = 1'b1;
    logic       bus_sda;
    logic       sda_oe;
    logic       busy;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;

    assign bus_sda = m_rel & ~sda_oe;

    always #5 clk = ~clk;

    i2c_eeprom_slave #(
        .DEV_ADDR (7'h50),
        .MEM_DEPTH(256),
        .PAGE_SIZE(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i2c_scl   (scl),
        .i2c_sda_in(bus_sda),
        .i2c_sda_oe(sda_oe),
        .busy      (busy),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [7:0]  ref_mem [256];
    bit          known   [256];
    logic [7:0]  ref_ptr;
    logic [15:0] wr_q[$];

    always @(negedge clk) if (wr_valid) wr_q.push_back({wr_addr, wr_data});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Next write location: page-local increment when page wrap is enabled
    function automatic logic [7:0] wnext(input logic [7:0] a);
`ifdef I2C_SLV_PAGE_WRAP_EN
        return 8'((int'(a) / 8) * 8 + ((int'(a) % 8) + 1) % 8);
`else
        return 8'((int'(a) + 1) % 256);
`endif
    endfunction

    task automatic do_bit(input logic b, output logic rd);
        #(Q) m_rel = b;
        #(Q) scl = 1'b1;
        #(Q) rd = bus_sda;
        #(Q) scl = 1'b0;
    endtask

    task automatic m_start();
        #(Q) m_rel = 1'b1;
        #(Q) scl = 1'b1;
        #(2*Q) m_rel = 1'b0;
        #(2*Q) scl = 1'b0;
    endtask

    task automatic m_stop();
        #(Q) m_rel = 1'b0;
        #(Q) scl = 1'b1;
        #(2*Q) m_rel = 1'b1;
        #(2*Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic d;
        for (int i = 7; i >= 0; i--) do_bit(b[i], d);
        do_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] b);
        logic d;
        for (int i = 7; i >= 0; i--) begin
            do_bit(1'b1, d);
            b[i] = d;
        end
        do_bit(nack, d);
    endtask

    task automatic write_txn(input logic [7:0] addr, input logic [7:0] data[$], input string tag);
        logic        ack;
        logic [7:0]  p;
        logic [15:0] ev;
        wr_q.delete();
        m_start();
        send_byte(8'hA0, ack);
        check({tag, "_dack"}, ack, 0);
        send_byte(addr, ack);
        check({tag, "_aack"}, ack, 0);
        for (int i = 0; i < data.size(); i++) begin
            send_byte(data[i], ack);
            check({tag, "_wack"}, ack, 0);
        end
        check({tag, "_busy"}, busy, 1);
        m_stop();
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_nwr"}, wr_q.size(), data.size());
        p = addr;
        for (int i = 0; i < data.size(); i++) begin
            ev = (wr_q.size() > 0) ? wr_q.pop_front() : 16'hxxxx;
            check({tag, "_waddr"}, ev[15:8], p);
            check({tag, "_wdata"}, ev[7:0], data[i]);
            ref_mem[p] = data[i];
            known[p]   = 1'b1;
            p = wnext(p);
        end
        ref_ptr = p;
    endtask

    task automatic read_txn(input bit set_addr, input logic [7:0] addr, input int n, input string tag);
        logic       ack;
        logic [7:0] b;
        m_start();
        if (set_addr) begin
            send_byte(8'hA0, ack);
            check({tag, "_dack"}, ack, 0);
            send_byte(addr, ack);
            check({tag, "_aack"}, ack, 0);
            ref_ptr = addr;
            m_start();
        end
        send_byte(8'hA1, ack);
        check({tag, "_rack"}, ack, 0);
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, b);
            if (known[ref_ptr]) check({tag, "_data"}, b, ref_mem[ref_ptr]);
            ref_ptr = ref_ptr + 8'd1;
        end
        m_stop();
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_oe_end"}, sda_oe, 0);
    endtask

    initial begin
        logic [7:0] d[$];
        logic [7:0] a;
        logic       ack;
        logic       bit_v;
        int         n;

        for (int i = 0; i < 256; i++) known[i] = 1'b0;
        ref_ptr = 8'h00;

        repeat (5) @(posedge clk);
        #1;
        check("rst_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        d.delete(); d.push_back(8'hA5);
        write_txn(8'h10, d, "wr10");
        read_txn(1, 8'h10, 1, "rd10");

        // Foreign device address: no ACK, no write, never busy
        wr_q.delete();
        m_start();
        send_byte(8'hA2, ack);
        check("nack51_ack", ack, 1);
        check("nack51_busy", busy, 0);
        send_byte(8'h10, ack);
        check("nack51_ack2", ack, 1);
        m_stop();
        check("nack51_nwr", wr_q.size(), 0);
        check("nack51_busy_end", busy, 0);

        d.delete(); d.push_back(8'h11); d.push_back(8'h22); d.push_back(8'h33);
        write_txn(8'h06, d, "wr06");

        d.delete(); d.push_back(8'($urandom)); write_txn(8'hFE, d, "wrFE");
        d.delete(); d.push_back(8'($urandom)); write_txn(8'hFF, d, "wrFF");
        d.delete(); d.push_back(8'($urandom)); write_txn(8'h00, d, "wr00");
        read_txn(1, 8'hFE, 3, "rdFE");

        // STOP after 4 data bits: partial byte discarded
        wr_q.delete();
        m_start();
        send_byte(8'hA0, ack);
        send_byte(8'h30, ack);
        for (int i = 0; i < 4; i++) do_bit(1'($urandom), bit_v);
        m_stop();
        repeat (4) @(posedge clk);
        check("stop4_nwr", wr_q.size(), 0);
        check("stop4_oe", sda_oe, 0);
        check("stop4_busy", busy, 0);
        ref_ptr = 8'h30;
        d.delete(); d.push_back(8'h00);
        write_txn(8'h20, d, "wr20");

        // Reset while the slave is driving a 0 data bit
        m_start();
        send_byte(8'hA0, ack);
        send_byte(8'h20, ack);
        m_start();
        send_byte(8'hA1, ack);
        #(Q);
        check("rstmid_pre_oe", sda_oe, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_oe", sda_oe, 0);
        check("rstmid_busy", busy, 0);
        m_rel = 1'b1;
        #(Q) scl = 1'b1;
        #(2*Q) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        ref_ptr = 8'h00;
        read_txn(1, 8'h10, 1, "rstmid_mem");

        for (int it = 0; it < 10; it++) begin
            a = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 4);
            d.delete();
            for (int k = 0; k < n; k++) d.push_back(8'($urandom));
            write_txn(a, d, "rnd_wr");
            read_txn(1, a, n, "rnd_rd");
            if (it % 3 == 0) read_txn(0, 8'h00, 2, "rnd_cur");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
